ipv4_hdr_rewrite: RTL and testbench
===================================

# ipv4_hdr_rewrite

Streaming IPv4 header rewriter on the 32-bit packet path, directly upstream of `checksum_gen`. It buffers the 5-word IPv4 header and extracts DSCP, TTL and checksum. When a change is needed, it issues one incremental-checksum request to `checksum_gen`, then emits the header with rewritten DSCP, TTL and checksum, followed by the payload unchanged.

## Interface
- `GNT_TIMEOUT`, 15: cycles to wait for `cs_gnt` after `cs_req` before abandoning the rewrite.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid` / `in_ready`  in / out  1 / 1  input stream handshake.
- `in_data`  in  32  header/payload word, big-endian.
- `in_sop` / `in_eop`  in  1 / 1  first / last word of packet.
- `out_valid` / `out_ready`  out / in  1 / 1  output stream handshake.
- `out_data`  out  32; `out_sop` / `out_eop`  out  1 / 1.
- `cfg_dscp_en`  in  1  replace DSCP with `cfg_dscp`.
- `cfg_dscp`  in  6  new DSCP value.
- `cfg_ttl_dec`  in  1  decrement TTL.
- `cs_req`  out  1  single-cycle request pulse to `checksum_gen`.
- `cs_old_checksum`  out  16  header checksum as received.
- `cs_removed_val`  out  6  old DSCP.
- `cs_new_val`  out  6  new DSCP.
- `cs_dec_ttl`  out  1  TTL is being decremented.
- `cs_gnt`  in  1  one-cycle completion pulse.
- `cs_new_checksum`  in  16  valid in the `cs_gnt` cycle.
- `err_runt`  out  1  pulse: EOP before word 4.
- `err_cs_timeout`  out  1  pulse: no `cs_gnt` within `GNT_TIMEOUT`.
- `ttl_expired`  out  1  pulse: TTL==0 with `cfg_ttl_dec` set.

## Operation
- **Header fields**
  - Word0: `{ver[31:28], ihl[27:24], dscp[23:18], ecn[17:16], len[15:0]}`.
  - Word2: `{ttl[31:24], proto[23:16], csum[15:0]}`.
- **Config sampling:** `cfg_*` are captured on the SOP word and held for that packet.
- **IDLE**
  - `in_ready`=1.
  - Non-SOP words are accepted and dropped.
  - An SOP word is stored as word0, then go to CAPT.
- **CAPT**
  - `in_ready`=1; store words 1..4.
  - EOP before word4 (runt): go to FLUSH with unmodified words, pulse `err_runt`.
  - After word4 is accepted:
    - if ver≠4 or ihl≠5: go to HDR_OUT unmodified; options and payload pass through.
    - else compute `dec` = `cfg_ttl_dec` && ttl≠0.
    - if `cfg_ttl_dec` && ttl==0: pulse `ttl_expired`, `dec`=0.
    - compute `nd` = `cfg_dscp_en` ? `cfg_dscp` : dscp.
    - if `nd`==dscp and !`dec`: go to HDR_OUT unmodified.
    - else: go to REQ.
- **REQ**
  - `cs_req`=1 for exactly one cycle.
  - `cs_old_checksum`=csum, `cs_removed_val`=dscp, `cs_new_val`=`nd`, `cs_dec_ttl`=`dec`.
  - `cs_*` operands are held stable from REQ until exit from WAIT.
  - Go to WAIT.
- **WAIT**
  - `in_ready`=0; a counter runs.
  - On `cs_gnt`: patch word0[23:18]=`nd`, word2[31:24]=ttl−`dec`, word2[15:0]=`cs_new_checksum`, then go to HDR_OUT.
  - On counter==`GNT_TIMEOUT`: pulse `err_cs_timeout`, go to HDR_OUT unmodified.
- **HDR_OUT**
  - Emit the 5 buffered words; `out_sop` on word0.
  - Advance only on `out_valid`&&`out_ready`.
  - After word4: go to PASS.
- **PASS**
  - `out_valid`=`in_valid`, `in_ready`=`out_ready`, data and EOP pass combinationally.
  - On EOP transfer: go to IDLE.
- **FLUSH:** emit the stored runt words, `out_eop` on the last one, then go to IDLE.
- **Arithmetic:** TTL decrement is 8-bit with no wrap, since ttl==0 is never decremented. The checksum is taken verbatim from `checksum_gen`; this block performs no checksum arithmetic.
- **Mid-packet SOP in PASS:** treated as an ordinary word; the packet ends only on EOP.

## Timing
- **Reset:** asynchronous; all state is cleared immediately and the FSM returns to IDLE.
  - Outputs during and after reset: `out_valid`, `in_ready`, `cs_req`, all `err_*`, `ttl_expired` = 0; `out_data` and `cs_*` operand outputs = 0.
  - `in_ready` rises the first cycle after deassertion.
  - A packet in flight when reset asserts is lost; no partial output follows.
- **Rewrite latency:** with `checksum_gen`, `cs_req` comes 1 cycle after the word4 transfer and `cs_gnt` 3 cycles after `cs_req`. `out_valid` with word0 follows 1 cycle after `cs_gnt`, i.e. 5 cycles after the word4 accept.
- **Unmodified latency:** `out_valid` with word0 follows 1 cycle after the word4 accept.
- **`cs_gnt` outside WAIT** is ignored.
- **Simultaneous `cs_gnt` and timeout:** `cs_gnt` wins.
- **Backpressure:** `out_ready`=0 in HDR_OUT holds the current word stable; `out_data` must not change while `out_valid`&&!`out_ready`.
- **Throughput:** 1 word/cycle in PASS; header stall is 5 (+4 when a rewrite is requested) cycles.

## Structure
- **`ipv4_rw_pkg`:** state enum (IDLE, CAPT, REQ, WAIT, HDR_OUT, PASS, FLUSH), `HDR_WORDS`=5, field bit-position constants, `IPV4_VER`=4, `IPV4_IHL_MIN`=5.
- **Sub-modules:** none; `checksum_gen` is instantiated beside this block at the parent level.

## Test plan
- **DSCP + TTL rewrite:** 5-word header, word0=0x45000054, word2=0x40011234, `cfg_dscp_en`=1, `cfg_dscp`=0x2E, `cfg_ttl_dec`=1, checksum stub returns 0xBEEF.
  - Requires `cs_req` pulse with old=0x1234, rm=0, new=0x2E, dec=1.
  - Output word0=0x45B80054, word2=0x3F01BEEF.
- **No change needed:** `cfg_dscp_en`=0, `cfg_ttl_dec`=0 → no `cs_req`; header identical; word0 out 1 cycle after word4 accept.
- **TTL expired:** ttl=0x00, `cfg_ttl_dec`=1, `cfg_dscp_en`=0 → `ttl_expired` pulse, no `cs_req`, header unchanged.
- **Runt packet:** 3 words with EOP on word2 → `err_runt` pulse; 3 words out unchanged with `out_eop` on the third.
- **Checksum timeout:** stub never asserts `cs_gnt` → `err_cs_timeout` 15 cycles after `cs_req`; header emitted unmodified.
- **Backpressure and reset:**
  - Random `out_ready` over a 20-word packet → all words in order, no loss.
  - Assert `reset` while in WAIT → `out_valid`/`cs_req` drop immediately; the next packet is processed normally.

Source files
------------

// File: rtl/ipv4_rw_pkg.sv
// Shared types and IPv4 header field positions for the header rewriter.
package ipv4_rw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPT,
    REQ,
    WAIT,
    HDR_OUT,
    PASS,
    FLUSH
  } state_t;

  localparam int HDR_WORDS    = 5;
  localparam int IPV4_VER     = 4;
  localparam int IPV4_IHL_MIN = 5;

  // word0 fields
  localparam int VER_MSB  = 31;
  localparam int VER_LSB  = 28;
  localparam int IHL_MSB  = 27;
  localparam int IHL_LSB  = 24;
  localparam int DSCP_MSB = 23;
  localparam int DSCP_LSB = 18;

  // word2 fields
  localparam int TTL_MSB  = 31;
  localparam int TTL_LSB  = 24;
  localparam int CSUM_MSB = 15;
  localparam int CSUM_LSB = 0;

  localparam logic [2:0] LAST_HDR = 3'(HDR_WORDS - 1);

endpackage

// File: rtl/ipv4_hdr_rewrite.sv
// Buffers the 5-word IPv4 header, optionally rewrites DSCP/TTL using an
// incremental checksum from checksum_gen, then streams the payload through.
module ipv4_hdr_rewrite
  import ipv4_rw_pkg::*;
#(
  parameter int unsigned GNT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  input  logic        cfg_dscp_en,
  input  logic [5:0]  cfg_dscp,
  input  logic        cfg_ttl_dec,
  output logic        cs_req,
  output logic [15:0] cs_old_checksum,
  output logic [5:0]  cs_removed_val,
  output logic [5:0]  cs_new_val,
  output logic        cs_dec_ttl,
  input  logic        cs_gnt,
  input  logic [15:0] cs_new_checksum,
  output logic        err_runt,
  output logic        err_cs_timeout,
  output logic        ttl_expired
);

  state_t      state, state_nxt;
  logic [31:0] hdr [HDR_WORDS];
  logic [2:0]  cnt, idx, nwords;
  logic        eop4, up;
  logic        dscp_en_r, ttl_dec_r;
  logic [5:0]  dscp_cfg_r;
  logic [7:0]  tmr;
  logic [5:0]  dscp_old, nd;
  logic [7:0]  ttl_old;
  logic        dec, is_v4, go_req;

  assign dscp_old = hdr[0][DSCP_MSB:DSCP_LSB];
  assign ttl_old  = hdr[2][TTL_MSB:TTL_LSB];
  assign is_v4    = (hdr[0][VER_MSB:VER_LSB] == 4'(IPV4_VER)) &&
                    (hdr[0][IHL_MSB:IHL_LSB] == 4'(IPV4_IHL_MIN));
  assign dec      = ttl_dec_r && (ttl_old != 8'd0);
  assign nd       = dscp_en_r ? dscp_cfg_r : dscp_old;
  assign go_req   = is_v4 && ((nd != dscp_old) || dec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_sop        = 1'b0;
    out_eop        = 1'b0;
    cs_req         = 1'b0;
    err_runt       = 1'b0;
    err_cs_timeout = 1'b0;
    ttl_expired    = 1'b0;
    case (state)
      IDLE: begin
        // up keeps in_ready low until the first edge after reset release
        in_ready = up;
        if (up && in_valid && in_sop) begin
          if (in_eop) begin
            err_runt  = 1'b1;
            state_nxt = FLUSH;
          end else begin
            state_nxt = CAPT;
          end
        end
      end
      CAPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt == LAST_HDR) begin
            ttl_expired = is_v4 && ttl_dec_r && (ttl_old == 8'd0);
            state_nxt   = go_req ? REQ : HDR_OUT;
          end else if (in_eop) begin
            err_runt  = 1'b1;
            state_nxt = FLUSH;
          end
        end
      end
      REQ: begin
        cs_req    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cs_gnt) begin
          state_nxt = HDR_OUT;
        end else if (tmr == 8'd1) begin
          err_cs_timeout = 1'b1;
          state_nxt      = HDR_OUT;
        end
      end
      HDR_OUT: begin
        out_valid = 1'b1;
        out_data  = hdr[idx];
        out_sop   = (idx == 3'd0);
        out_eop   = eop4 && (idx == LAST_HDR);
        if (out_ready && (idx == LAST_HDR)) state_nxt = eop4 ? IDLE : PASS;
      end
      PASS: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        out_data  = in_data;
        out_eop   = in_eop;
        if (in_valid && out_ready && in_eop) state_nxt = IDLE;
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_data  = hdr[idx];
        out_sop   = (idx == 3'd0);
        out_eop   = (idx == nwords - 3'd1);
        if (out_ready && (idx == nwords - 3'd1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HDR_WORDS; i++) hdr[i] <= '0;
      cnt             <= '0;
      idx             <= '0;
      nwords          <= '0;
      eop4            <= 1'b0;
      up              <= 1'b0;
      dscp_en_r       <= 1'b0;
      ttl_dec_r       <= 1'b0;
      dscp_cfg_r      <= '0;
      tmr             <= '0;
      cs_old_checksum <= '0;
      cs_removed_val  <= '0;
      cs_new_val      <= '0;
      cs_dec_ttl      <= 1'b0;
    end else begin
      up <= 1'b1;
      case (state)
        IDLE: begin
          if (up && in_valid && in_sop) begin
            hdr[0]     <= in_data;
            cnt        <= 3'd1;
            nwords     <= 3'd1;
            idx        <= '0;
            eop4       <= 1'b0;
            dscp_en_r  <= cfg_dscp_en;
            dscp_cfg_r <= cfg_dscp;
            ttl_dec_r  <= cfg_ttl_dec;
          end
        end
        CAPT: begin
          if (in_valid) begin
            hdr[cnt] <= in_data;
            cnt      <= cnt + 3'd1;
            nwords   <= cnt + 3'd1;
            eop4     <= in_eop;
            // operands stay frozen until the next rewrite decision
            if ((cnt == LAST_HDR) && go_req) begin
              cs_old_checksum <= hdr[2][CSUM_MSB:CSUM_LSB];
              cs_removed_val  <= dscp_old;
              cs_new_val      <= nd;
              cs_dec_ttl      <= dec;
            end
          end
        end
        REQ: tmr <= 8'(GNT_TIMEOUT);
        WAIT: begin
          if (cs_gnt) begin
            hdr[0][DSCP_MSB:DSCP_LSB] <= cs_new_val;
            hdr[2][TTL_MSB:TTL_LSB]   <= ttl_old - {7'd0, cs_dec_ttl};
            hdr[2][CSUM_MSB:CSUM_LSB] <= cs_new_checksum;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        HDR_OUT, FLUSH: if (out_ready) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_hdr_rewrite.sv
// Self-checking bench for ipv4_hdr_rewrite with a checksum_gen stub and a
// packet-level reference model.
module tb_ipv4_hdr_rewrite;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid, out_sop, out_eop;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;
  logic        cfg_dscp_en = 1'b0, cfg_ttl_dec = 1'b0;
  logic [5:0]  cfg_dscp = '0;
  logic        cs_req, cs_dec_ttl;
  logic [15:0] cs_old_checksum;
  logic [5:0]  cs_removed_val, cs_new_val;
  logic        cs_gnt = 1'b0;
  logic [15:0] cs_new_checksum = '0;
  logic        err_runt, err_cs_timeout, ttl_expired;

  ipv4_hdr_rewrite #(.GNT_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .cfg_dscp_en(cfg_dscp_en), .cfg_dscp(cfg_dscp), .cfg_ttl_dec(cfg_ttl_dec),
    .cs_req(cs_req), .cs_old_checksum(cs_old_checksum),
    .cs_removed_val(cs_removed_val), .cs_new_val(cs_new_val),
    .cs_dec_ttl(cs_dec_ttl), .cs_gnt(cs_gnt), .cs_new_checksum(cs_new_checksum),
    .err_runt(err_runt), .err_cs_timeout(err_cs_timeout), .ttl_expired(ttl_expired)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;

  logic [31:0] sq_d[$];
  bit          sq_s[$], sq_e[$];
  bit          in_fire_s = 1'b0;

  logic [31:0] od[$];
  bit          os[$], oe[$];
  int n_req, n_runt, n_tout, n_texp, pkt_in, stall_err, op_unstable;
  int req_cyc, tout_cyc, w4_cyc, fo_cyc;
  logic [15:0] rq_old;
  logic [5:0]  rq_rm, rq_new;
  logic        rq_dec;
  bit          hold_act = 1'b0, prev_stall = 1'b0, gnt_en = 1'b1, bp_en = 1'b0;
  logic [31:0] prev_d = '0;
  logic [15:0] stub_cs = '0;
  int          gnt_cd = -1;

  logic [31:0] ew[$];
  bit          es[$], ee[$];
  int          e_req, e_runt, e_texp, e_tout;
  logic [15:0] e_old;
  logic [5:0]  e_rm, e_new;
  logic        e_dec;

  // monitor: everything sampled on the falling edge
  always @(negedge clk) begin
    in_fire_s = in_valid && in_ready;
    if (in_fire_s) begin
      pkt_in++;
      if (pkt_in == 5) w4_cyc = cyc;
    end
    if (out_valid && out_sop && fo_cyc < 0) fo_cyc = cyc;
    if (prev_stall && (!out_valid || out_data !== prev_d)) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_d     = out_data;
    if (out_valid && out_ready) begin
      od.push_back(out_data); os.push_back(out_sop); oe.push_back(out_eop);
    end
    if (cs_req) begin
      n_req++; req_cyc = cyc; hold_act = 1'b1;
      rq_old = cs_old_checksum; rq_rm = cs_removed_val; rq_new = cs_new_val; rq_dec = cs_dec_ttl;
      if (gnt_en) gnt_cd = 3;
    end else if (hold_act && {cs_old_checksum, cs_removed_val, cs_new_val, cs_dec_ttl} !==
                             {rq_old, rq_rm, rq_new, rq_dec}) begin
      op_unstable++;
    end
    if (cs_gnt) hold_act = 1'b0;
    if (err_runt) n_runt++;
    if (err_cs_timeout) begin n_tout++; tout_cyc = cyc; hold_act = 1'b0; end
    if (ttl_expired) n_texp++;
  end

  // driver: source queue, random sink readiness, checksum_gen stub
  always @(posedge clk) begin
    cyc++;
    #1;
    if (in_fire_s && sq_d.size() > 0) begin
      void'(sq_d.pop_front()); void'(sq_s.pop_front()); void'(sq_e.pop_front());
    end
    in_fire_s = 1'b0;
    if (sq_d.size() > 0) begin
      in_valid = 1'b1; in_data = sq_d[0]; in_sop = sq_s[0]; in_eop = sq_e[0];
    end else begin
      in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    end
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    cs_gnt = 1'b0; cs_new_checksum = '0;
    if (gnt_cd > 0) gnt_cd--;
    if (gnt_cd == 0) begin cs_gnt = 1'b1; cs_new_checksum = stub_cs; gnt_cd = -1; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: header rules applied to a whole packet
  task automatic set_model(input logic [31:0] w[$], input bit den, input logic [5:0] dv,
                           input bit tdec, input bit gnt, input logic [15:0] cs);
    logic [31:0] w0, w2;
    logic [7:0]  ttl;
    logic [5:0]  ds, nd;
    bit          dec;
    ew.delete(); es.delete(); ee.delete();
    e_req = 0; e_texp = 0; e_tout = 0; e_old = '0; e_rm = '0; e_new = '0; e_dec = 1'b0;
    foreach (w[i]) begin
      ew.push_back(w[i]); es.push_back(i == 0); ee.push_back(i == w.size() - 1);
    end
    e_runt = (w.size() < 5) ? 1 : 0;
    if (w.size() >= 5) begin
      w0 = w[0]; w2 = w[2];
      if (w0[31:28] == 4'd4 && w0[27:24] == 4'd5) begin
        ttl = w2[31:24]; ds = w0[23:18];
        e_texp = (tdec && ttl == 8'd0) ? 1 : 0;
        dec = tdec && ttl != 8'd0;
        nd = den ? dv : ds;
        if (nd != ds || dec) begin
          e_req = 1; e_old = w2[15:0]; e_rm = ds; e_new = nd; e_dec = dec;
          if (gnt) begin
            w0[23:18] = nd;
            w2 = {ttl - 8'(dec), w2[23:16], cs};
            ew[0] = w0; ew[2] = w2;
          end else begin
            e_tout = 1;
          end
        end
      end
    end
  endtask

  task automatic start_pkt(input logic [31:0] w[$]);
    od.delete(); os.delete(); oe.delete();
    n_req = 0; n_runt = 0; n_tout = 0; n_texp = 0; pkt_in = 0;
    stall_err = 0; op_unstable = 0; fo_cyc = -1; w4_cyc = -1; req_cyc = -1; tout_cyc = -1;
    foreach (w[i]) begin
      sq_d.push_back(w[i]); sq_s.push_back(i == 0); sq_e.push_back(i == w.size() - 1);
    end
  endtask

  task automatic drive_pkt(input logic [31:0] w[$], input bit den, input logic [5:0] dv,
                           input bit tdec, input bit gnt, input logic [15:0] cs, input bit scramble);
    int k = 0;
    cfg_dscp_en = den; cfg_dscp = dv; cfg_ttl_dec = tdec; gnt_en = gnt; stub_cs = cs;
    set_model(w, den, dv, tdec, gnt, cs);
    start_pkt(w);
    while ((od.size() < ew.size() || sq_d.size() > 0) && k < 400) begin
      @(negedge clk); k++;
      if (scramble && pkt_in >= 1) begin
        cfg_dscp_en = 1'($urandom); cfg_dscp = 6'($urandom); cfg_ttl_dec = 1'($urandom);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, out_valid, cs_req, err_runt, err_cs_timeout, ttl_expired} !== 6'b0) begin
      fails++; $display("FAIL reset_ctl got %b want 000000",
        {in_ready, out_valid, cs_req, err_runt, err_cs_timeout, ttl_expired});
    end
    tests++;
    if ({out_data, cs_old_checksum, cs_removed_val, cs_new_val, cs_dec_ttl} !== 61'd0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h/%h/%b want zeros",
        out_data, cs_old_checksum, cs_removed_val, cs_new_val, cs_dec_ttl);
    end
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ready_early got %b want 0", in_ready); end
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_rise got %b want 1", in_ready); end
  endtask

  task automatic test_dscp_ttl;
    logic [31:0] w[$] = '{32'h45000054, 32'h1c460000, 32'h40011234, 32'hc0a80001,
                          32'hc0a800c7, 32'hdeadbeef, 32'h01020304};
    drive_pkt(w, 1'b1, 6'h2e, 1'b1, 1'b1, 16'hbeef, 1'b0);
    tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL dscp_ttl count got %0d want %0d", od.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL dscp_ttl word%0d got %h sop%b eop%b want %h sop%b eop%b", i, od[i], os[i], oe[i], ew[i], es[i], ee[i]); end
    end
    tests++; if (od.size() >= 3 && (od[0] !== 32'h45b80054 || od[2] !== 32'h3f01beef)) begin fails++;
      $display("FAIL dscp_ttl literal got %h %h want 45b80054 3f01beef", od[0], od[2]); end
    tests++; if (n_req != 1 || {rq_old, rq_rm, rq_new, rq_dec} !== {16'h1234, 6'h00, 6'h2e, 1'b1}) begin fails++;
      $display("FAIL dscp_ttl req n=%0d got %h/%h/%h/%b want 1234/00/2e/1", n_req, rq_old, rq_rm, rq_new, rq_dec); end
    tests++; if (fo_cyc - w4_cyc != 5) begin fails++; $display("FAIL dscp_ttl latency got %0d want 5", fo_cyc - w4_cyc); end
  endtask

  task automatic test_no_change;
    logic [31:0] w[$] = '{32'h45280054, 32'h00000000, 32'h40065555, 32'h0a000001, 32'h0a000002, 32'h11111111};
    drive_pkt(w, 1'b0, 6'h3f, 1'b0, 1'b1, 16'h0bad, 1'b0);
    tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL no_change count got %0d want %0d", od.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL no_change word%0d got %h sop%b eop%b want %h sop%b eop%b", i, od[i], os[i], oe[i], ew[i], es[i], ee[i]); end
    end
    tests++; if (n_req != 0) begin fails++; $display("FAIL no_change req got %0d want 0", n_req); end
    tests++; if (fo_cyc - w4_cyc != 1) begin fails++; $display("FAIL no_change latency got %0d want 1", fo_cyc - w4_cyc); end
  endtask

  task automatic test_ttl_expired;
    logic [31:0] w[$] = '{32'h45000054, 32'h00000000, 32'h00117777, 32'h0a000001, 32'h0a000002, 32'h22222222};
    drive_pkt(w, 1'b0, 6'h00, 1'b1, 1'b1, 16'h0bad, 1'b0);
    tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL ttl_exp count got %0d want %0d", od.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL ttl_exp word%0d got %h want %h", i, od[i], ew[i]); end
    end
    tests++; if (n_texp != 1 || n_req != 0) begin fails++; $display("FAIL ttl_exp pulses got texp=%0d req=%0d want 1/0", n_texp, n_req); end
  endtask

  task automatic test_runt;
    logic [31:0] w[$] = '{32'h45000054, 32'haaaa5555, 32'h40011234};
    drive_pkt(w, 1'b1, 6'h2e, 1'b1, 1'b1, 16'hbeef, 1'b0);
    tests++; if (od.size() != 3) begin fails++; $display("FAIL runt count got %0d want 3", od.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL runt word%0d got %h sop%b eop%b want %h sop%b eop%b", i, od[i], os[i], oe[i], ew[i], es[i], ee[i]); end
    end
    tests++; if (n_runt != 1 || n_req != 0) begin fails++; $display("FAIL runt pulses got runt=%0d req=%0d want 1/0", n_runt, n_req); end
  endtask

  task automatic test_timeout;
    logic [31:0] w[$] = '{32'h45000054, 32'h00000000, 32'h40011234, 32'h0a000001, 32'h0a000002, 32'h33333333};
    drive_pkt(w, 1'b1, 6'h0a, 1'b1, 1'b0, 16'hbeef, 1'b0);
    tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL timeout count got %0d want %0d", od.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL timeout word%0d got %h want %h", i, od[i], ew[i]); end
    end
    tests++; if (n_req != 1 || n_tout != 1) begin fails++; $display("FAIL timeout pulses got req=%0d tout=%0d want 1/1", n_req, n_tout); end
    tests++; if (tout_cyc - req_cyc != 15) begin fails++; $display("FAIL timeout delay got %0d want 15", tout_cyc - req_cyc); end
    tests++; if (op_unstable != 0) begin fails++; $display("FAIL timeout operands moved %0d times want 0", op_unstable); end
  endtask

  task automatic test_idle_drop;
    logic [31:0] w[$] = '{32'h45040054, 32'h00000000, 32'h80015678, 32'h0a000001, 32'h0a000002};
    sq_d.push_back(32'hf00df00d); sq_s.push_back(1'b0); sq_e.push_back(1'b0);
    sq_d.push_back(32'hcafecafe); sq_s.push_back(1'b0); sq_e.push_back(1'b1);
    drive_pkt(w, 1'b0, 6'h00, 1'b1, 1'b1, 16'h4242, 1'b0);
    tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL idle_drop count got %0d want %0d", od.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL idle_drop word%0d got %h sop%b eop%b want %h sop%b eop%b", i, od[i], os[i], oe[i], ew[i], es[i], ee[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w[$];
    w.push_back(32'h45100400); w.push_back(32'h12345678); w.push_back(32'h7f06abcd);
    for (int i = 3; i < 20; i++) w.push_back($urandom);
    bp_en = 1'b1;
    drive_pkt(w, 1'b1, 6'h15, 1'b1, 1'b1, 16'h5a5a, 1'b0);
    bp_en = 1'b0;
    tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL backpressure count got %0d want %0d", od.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL backpressure word%0d got %h sop%b eop%b want %h sop%b eop%b", i, od[i], os[i], oe[i], ew[i], es[i], ee[i]); end
    end
    tests++; if (stall_err != 0) begin fails++; $display("FAIL backpressure hold got %0d changes want 0", stall_err); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] w[$] = '{32'h45000054, 32'h00000000, 32'h40011234, 32'h0a000001, 32'h0a000002, 32'h44444444};
    logic [31:0] w2[$] = '{32'h45fc0054, 32'h00000000, 32'h02119999, 32'h0a000003, 32'h0a000004, 32'h55555555};
    int k = 0;
    cfg_dscp_en = 1'b1; cfg_dscp = 6'h11; cfg_ttl_dec = 1'b1; gnt_en = 1'b0;
    start_pkt(w);
    while (n_req == 0 && k < 100) begin @(negedge clk); k++; end
    tests++; if (n_req != 1) begin fails++; $display("FAIL rst_wait reached got req=%0d want 1", n_req); end
    @(negedge clk); #2 reset = 1'b1; #1;
    tests++;
    if ({out_valid, cs_req, in_ready} !== 3'b000 || {out_data, cs_old_checksum, cs_new_val, cs_dec_ttl} !== 55'd0) begin
      fails++; $display("FAIL rst_wait drop got v%b req%b rdy%b data %h old %h want all zero",
        out_valid, cs_req, in_ready, out_data, cs_old_checksum);
    end
    sq_d.delete(); sq_s.delete(); sq_e.delete(); hold_act = 1'b0; gnt_cd = -1;
    repeat (3) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || cs_req !== 1'b0) begin fails++;
        $display("FAIL rst_wait held got v%b req%b want 0/0", out_valid, cs_req); end
    end
    #2 reset = 1'b0;
    drive_pkt(w2, 1'b1, 6'h01, 1'b1, 1'b1, 16'h7777, 1'b0);
    tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL rst_next count got %0d want %0d", od.size(), ew.size()); end
    for (int i = 0; i < ew.size() && i < od.size(); i++) begin
      tests++;
      if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
        $display("FAIL rst_next word%0d got %h want %h", i, od[i], ew[i]); end
    end
  endtask

  task automatic test_random;
    logic [31:0] w[$];
    logic [31:0] w0, w2;
    int n;
    bit den, tdec, gnt;
    logic [5:0] dv;
    logic [15:0] cs;
    for (int p = 0; p < 30; p++) begin
      n  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 5 + $urandom_range(0, 5);
      w0 = {($urandom_range(0, 7) == 0) ? 4'h6 : 4'h4, ($urandom_range(0, 7) == 0) ? 4'h6 : 4'h5,
            6'($urandom), 2'($urandom), 16'($urandom)};
      w2 = {($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), 8'($urandom), 16'($urandom)};
      w.delete();
      for (int i = 0; i < n; i++) w.push_back(i == 0 ? w0 : (i == 2 ? w2 : $urandom));
      den = 1'($urandom); dv = 6'($urandom); tdec = 1'($urandom);
      gnt = ($urandom_range(0, 5) != 0); cs = 16'($urandom);
      bp_en = 1'($urandom);
      drive_pkt(w, den, dv, tdec, gnt, cs, 1'b1);
      bp_en = 1'b0;
      tests++; if (od.size() != ew.size()) begin fails++; $display("FAIL rand%0d count got %0d want %0d", p, od.size(), ew.size()); end
      for (int i = 0; i < ew.size() && i < od.size(); i++) begin
        tests++;
        if ({od[i], os[i], oe[i]} !== {ew[i], es[i], ee[i]}) begin fails++;
          $display("FAIL rand%0d word%0d got %h sop%b eop%b want %h sop%b eop%b", p, i, od[i], os[i], oe[i], ew[i], es[i], ee[i]); end
      end
      tests++;
      if (n_req != e_req || n_runt != e_runt || n_texp != e_texp || n_tout != e_tout) begin fails++;
        $display("FAIL rand%0d pulses got req%0d runt%0d texp%0d tout%0d want req%0d runt%0d texp%0d tout%0d",
          p, n_req, n_runt, n_texp, n_tout, e_req, e_runt, e_texp, e_tout); end
      if (e_req == 1) begin
        tests++;
        if ({rq_old, rq_rm, rq_new, rq_dec} !== {e_old, e_rm, e_new, e_dec}) begin fails++;
          $display("FAIL rand%0d operands got %h/%h/%h/%b want %h/%h/%h/%b",
            p, rq_old, rq_rm, rq_new, rq_dec, e_old, e_rm, e_new, e_dec); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dscp_ttl();
    test_no_change();
    test_ttl_expired();
    test_runt();
    test_timeout();
    test_idle_drop();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
